// File: rtl/shift_exec_pipe_pkg.sv
`default_nettype none
//============================================================================
// Package : shift_pkg
// Brief   : Shared op encodings, widths and helpers for the shift pipe.
// Rev     : 1.0 - initial release
//============================================================================
package shift_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef logic [2:0] shop_t;

    localparam shop_t SHOP_SLL = 3'b000;
    localparam shop_t SHOP_SRL = 3'b001;
    localparam shop_t SHOP_SRA = 3'b010;
    localparam shop_t SHOP_ROL = 3'b011;
    localparam shop_t SHOP_ROR = 3'b100;

    // Word ops only look at the low five amount bits.
    localparam logic [5:0] WORD_AMT_MASK = 6'h1F;

    // Encodings 101-111 are never legal; rotates are legal only when built in.
    function automatic logic shop_illegal(input shop_t op);
`ifdef SHIFT_EXEC_ROTATE_EN
        return (op > SHOP_ROR);
`else
        return !((op == SHOP_SLL) || (op == SHOP_SRL) || (op == SHOP_SRA));
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_exec_pipe_core.sv
`default_nettype none
//============================================================================
// Module : shift_core
// Brief  : Combinational six-stage logarithmic shifter (1/2/4/8/16/32) with
//          logical/arithmetic shifts, optional rotates and 32-bit word mode.
//          Rotates exist only when SHIFT_EXEC_ROTATE_EN is defined.
// Rev    : 1.0 - initial release
//============================================================================
module shift_core
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [5:0]      amt,
    input  logic            left,
    input  logic            arith,
    input  logic            rotate,
    input  logic            word,
    output logic [XLEN-1:0] result
);

    // Stage values; in word mode only the low 32 bits are meaningful.
    logic [XLEN-1:0] w_st [0:6];
    logic [XLEN-1:0] w_final;

    assign w_st[0] = word ? {32'b0, a[31:0]} : a;

    for (genvar k = 0; k < 6; k++) begin : g_stage
        localparam int C_S = 1 << k;

        logic [XLEN-1:0]        w_in;
        logic [XLEN-1:0]        w_l64;
        logic [XLEN-1:0]        w_r64;
        logic [XLEN-1:0]        w_sr64;
        logic signed [XLEN-1:0] w_sra64;
        logic [31:0]            w_lo;
        logic [31:0]            w_l32;
        logic [31:0]            w_r32;

        assign w_in    = w_st[k];
        assign w_lo    = w_in[31:0];
        assign w_sra64 = $signed(w_in) >>> C_S;
        assign w_sr64  = arith ? w_sra64 : (w_in >> C_S);

`ifdef SHIFT_EXEC_ROTATE_EN
        assign w_l64 = rotate ? ((w_in << C_S) | (w_in >> (XLEN - C_S))) : (w_in << C_S);
        assign w_r64 = rotate ? ((w_in >> C_S) | (w_in << (XLEN - C_S))) : w_sr64;
`else
        assign w_l64 = w_in << C_S;
        assign w_r64 = w_sr64;
`endif

        if (k < 5) begin : g_word_sh
            logic signed [31:0] w_sra32;
            logic [31:0]        w_sr32;

            assign w_sra32 = $signed(w_lo) >>> C_S;
            assign w_sr32  = arith ? w_sra32 : (w_lo >> C_S);
`ifdef SHIFT_EXEC_ROTATE_EN
            assign w_l32 = rotate ? ((w_lo << C_S) | (w_lo >> (32 - C_S))) : (w_lo << C_S);
            assign w_r32 = rotate ? ((w_lo >> C_S) | (w_lo << (32 - C_S))) : w_sr32;
`else
            assign w_l32 = w_lo << C_S;
            assign w_r32 = w_sr32;
`endif
        end else begin : g_word_pass
            // Word amounts never reach the 32 stage; pass through.
            assign w_l32 = w_lo;
            assign w_r32 = w_lo;
        end

        assign w_st[k+1] = !amt[k] ? w_in :
                           word    ? {32'b0, (left ? w_l32 : w_r32)} :
                                     (left ? w_l64 : w_r64);
    end

    assign w_final = word ? {{32{w_st[6][31]}}, w_st[6][31:0]} : w_st[6];

`ifdef SHIFT_EXEC_ROTATE_EN
    assign result = w_final;
`else
    // Without rotate hardware a rotate request has no defined result.
    assign result = rotate ? '0 : w_final;
`endif

endmodule
`default_nettype wire

// File: rtl/shift_exec_pipe.sv
`default_nettype none
//============================================================================
// Module : shift_exec_pipe
// Brief  : Two-stage valid/ready shift execution unit for RV64 (incl. *W
//          word ops). S1 registers operands and the normalised amount, S2
//          registers the shift_core result. Optional macro
//          SHIFT_EXEC_ROTATE_EN enables ROL/ROR.
// Rev    : 1.0 - initial release
//============================================================================
module shift_exec_pipe
    import shift_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [5:0]       in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic             r_s1_valid;
    shop_t            r_s1_op;
    logic             r_s1_word;
    logic [XLEN-1:0]  r_s1_a;
    logic [5:0]       r_s1_amt;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [XLEN-1:0]  r_s2_data;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_illegal;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [5:0]       w_amt_eff;
    logic             w_s1_illegal;
    logic             w_left;
    logic             w_arith;
    logic             w_rotate;
    logic [XLEN-1:0]  w_core_result;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv && !flush;
    assign w_amt_eff = in_word ? (in_amt & WORD_AMT_MASK) : in_amt;

    assign w_s1_illegal = shop_illegal(r_s1_op);
    assign w_left       = (r_s1_op == SHOP_SLL) || (r_s1_op == SHOP_ROL);
    assign w_arith      = (r_s1_op == SHOP_SRA);
    assign w_rotate     = (r_s1_op == SHOP_ROL) || (r_s1_op == SHOP_ROR);

    shift_core #(
        .XLEN   (XLEN)
    ) u_core (
        .a      (r_s1_a),
        .amt    (r_s1_amt),
        .left   (w_left),
        .arith  (w_arith),
        .rotate (w_rotate),
        .word   (r_s1_word),
        .result (w_core_result)
    );

    // Stage 1: capture an accepted request; flush kills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= SHOP_SLL;
            r_s1_word  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_amt   <= '0;
            r_s1_tag   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op   <= in_op;
                r_s1_word <= in_word;
                r_s1_a    <= in_a;
                r_s1_amt  <= w_amt_eff;
                r_s1_tag  <= in_tag;
            end
        end
    end

    // Stage 2: register the result; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_data    <= '0;
            r_s2_tag     <= '0;
            r_s2_illegal <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data    <= w_s1_illegal ? '0 : w_core_result;
                r_s2_tag     <= r_s1_tag;
                r_s2_illegal <= w_s1_illegal;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_data    = r_s2_data;
    assign out_tag     = r_s2_tag;
    assign out_illegal = r_s2_illegal;

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_pipe.sv
`default_nettype none
//============================================================================
// Module : tb_shift_exec_pipe
// Brief  : Self-checking bench for shift_exec_pipe: directed vector table,
//          backpressure stream, flush and mid-stream reset sequences.
// Rev    : 1.0 - initial release
//============================================================================
module tb_shift_exec_pipe;
    import shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_word;
    logic [63:0] in_a;
    logic [5:0]  in_amt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [5:0]  amt;
        logic [63:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    shift_exec_pipe #(
        .XLEN        (64),
        .TAG_W       (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_word     (in_word),
        .in_a        (in_a),
        .in_amt      (in_amt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic word, input logic [63:0] a,
                       input logic [5:0] amt, input logic [63:0] exp_data, input logic exp_ill);
        vec_t v;
        v.op = op; v.word = word; v.a = a; v.amt = amt;
        v.exp_data = exp_data; v.exp_ill = exp_ill;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] op, input logic word, input logic [63:0] a,
                         input logic [5:0] amt, input logic [4:0] tag);
        in_valid = 1'b1; in_op = op; in_word = word; in_a = a; in_amt = amt; in_tag = tag;
    endtask

    // One isolated request: accepted on the first edge, result two cycles later.
    task automatic apply(input vec_t v, input logic [4:0] tag);
        @(negedge clk);
        drive(v.op, v.word, v.a, v.amt, tag);
        #1 check($sformatf("v%0d_in_ready", tag), in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_early_valid", tag), out_valid, 0);
        @(negedge clk);
        check($sformatf("v%0d_valid", tag), out_valid, 1);
        check($sformatf("v%0d_data", tag), out_data, v.exp_data);
        check($sformatf("v%0d_illegal", tag), out_illegal, v.exp_ill);
        check($sformatf("v%0d_tag", tag), out_tag, tag);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_word = 1'b0;
        in_a = '0; in_amt = '0; in_tag = '0; out_ready = 1'b1;

        add(SHOP_SLL, 0, 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000, 0);
        add(SHOP_SRA, 0, 64'h8000_0000_0000_0000, 6'd4,  64'hF800_0000_0000_0000, 0);
        add(SHOP_SRL, 0, 64'h8000_0000_0000_0000, 6'd4,  64'h0800_0000_0000_0000, 0);
        add(SHOP_SLL, 1, 64'h0000_0000_4000_0000, 6'h21, 64'hFFFF_FFFF_8000_0000, 0);
        add(SHOP_SRA, 1, 64'h0000_0000_8000_0000, 6'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        add(SHOP_SLL, 0, 64'h1234_5678_9ABC_DEF0, 6'd0,  64'h1234_5678_9ABC_DEF0, 0);
        add(SHOP_SRL, 1, 64'h0000_0000_8765_4321, 6'd0,  64'hFFFF_FFFF_8765_4321, 0);
        add(SHOP_SRL, 1, 64'hFFFF_FFFF_8000_0000, 6'd4,  64'h0000_0000_0800_0000, 0);
        add(SHOP_SRA, 0, 64'h7000_0000_0000_0000, 6'd60, 64'h0000_0000_0000_0007, 0);
        add(SHOP_SLL, 1, 64'hFFFF_FFFF_0000_0001, 6'd31, 64'hFFFF_FFFF_8000_0000, 0);
        add(SHOP_SRL, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h0000_0000_0000_0001, 0);
        add(SHOP_SRA, 0, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        add(SHOP_SRL, 1, 64'h0000_0000_8000_0000, 6'h3F, 64'h0000_0000_0000_0001, 0);
        add(3'b111,   0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1,  64'h0, 1);
        add(3'b101,   1, 64'h0000_0000_1234_5678, 6'd3,  64'h0, 1);
`ifdef SHIFT_EXEC_ROTATE_EN
        add(SHOP_ROR, 0, 64'h0000_0000_0000_0001, 6'd1,  64'h8000_0000_0000_0000, 0);
        add(SHOP_ROL, 0, 64'h8000_0000_0000_0001, 6'd4,  64'h0000_0000_0000_0018, 0);
        add(SHOP_ROR, 1, 64'h0000_0000_0000_0001, 6'd1,  64'hFFFF_FFFF_8000_0000, 0);
        add(SHOP_ROL, 1, 64'hDEAD_BEEF_8000_0001, 6'd36, 64'h0000_0000_0000_0018, 0);
        add(SHOP_ROR, 0, 64'h0123_4567_89AB_CDEF, 6'd32, 64'h89AB_CDEF_0123_4567, 0);
`else
        add(SHOP_ROR, 0, 64'h0000_0000_0000_0001, 6'd1,  64'h0, 1);
        add(SHOP_ROL, 0, 64'h8000_0000_0000_0001, 6'd4,  64'h0, 1);
        add(SHOP_ROR, 1, 64'h0000_0000_0000_0001, 6'd1,  64'h0, 1);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_illegal", out_illegal, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 5'(i));

        // Back-to-back stream of 8 with out_ready low for 5 cycles
        begin
            int sent, got;
            logic held;
            logic [63:0] held_d;
            logic [4:0]  held_t;
            logic [63:0] exp_d;
            sent = 0; got = 0; held = 1'b0; held_d = '0; held_t = '0;
            for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 3 && cyc < 8);
                if (sent < 8) drive(SHOP_SLL, 0, 64'hA5A5_0000_0000_0000 | 64'(sent), 6'(sent), 5'(sent));
                else in_valid = 1'b0;
                #1;
                if (held) begin
                    check("stall_valid_hold", out_valid, 1);
                    check("stall_data_hold", out_data, held_d);
                    check("stall_tag_hold", out_tag, held_t);
                end
                check($sformatf("stream_in_ready_c%0d", cyc), in_ready,
                      (out_ready || (sent - got) < 2) ? 1 : 0);
                if (out_valid && out_ready) begin
                    exp_d = (64'hA5A5_0000_0000_0000 | 64'(got)) << got;
                    check($sformatf("stream_tag_%0d", got), out_tag, got);
                    check($sformatf("stream_data_%0d", got), out_data, exp_d);
                    got++;
                end
                held   = out_valid && !out_ready;
                held_d = out_data;
                held_t = out_tag;
                if (in_valid && in_ready) sent++;
            end
            in_valid = 1'b0; out_ready = 1'b1;
            check("stream_delivered", got, 8);
            @(negedge clk);
            check("stream_no_extra", out_valid, 0);
        end

        // Flush with both stages full and a new request pending
        @(negedge clk);
        out_ready = 1'b0;
        drive(SHOP_SLL, 0, 64'h1, 6'd1, 5'd20);
        @(negedge clk);
        drive(SHOP_SLL, 0, 64'h2, 6'd1, 5'd21);
        @(negedge clk);
        drive(SHOP_SLL, 0, 64'h3, 6'd1, 5'd22);
        flush = 1'b1;
        #1;
        check("flush_full_valid", out_valid, 1);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("flush_drain_c%0d", c), out_valid, 0);
        end
        apply(vecs[1], 5'd23);

        // Asynchronous reset while a result is held and another is in S1
        @(negedge clk);
        out_ready = 1'b0;
        drive(SHOP_SLL, 0, 64'h3, 6'd1, 5'd9);
        @(negedge clk);
        drive(SHOP_SRL, 0, 64'hF0, 6'd4, 5'd10);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rstmid_pre_valid", out_valid, 1);
        check("rstmid_pre_data", out_data, 64'h6);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_data", out_data, 0);
        check("rstmid_out_tag", out_tag, 0);
        check("rstmid_out_illegal", out_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rstmid_drain_c%0d", c), out_valid, 0);
        end
        apply(vecs[3], 5'd24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_exec_pipe.md
Name: shift_exec_pipe

Overview:
- Two-stage pipelined shift execution unit for the 64-bit integer datapath; sits between issue/operand read and writeback.
- Accepts one shift request per cycle over valid/ready, normalises the amount, and registers operands in stage 1.
- Computes the result with a log-stage shift core in stage 2 and presents it, with its tag, over valid/ready to writeback.
- Supports RV64 word ops (*W forms): operate on the low 32 bits, sign-extend the 32-bit result.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TAG_W, 5, width of the opaque destination tag carried alongside each request.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight requests.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal.
- in_word  in  1  1 = 32-bit word op.
- in_a  in  64  operand to shift.
- in_amt  in  6  shift amount.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  64  result.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  op was illegal or disabled; out_data is 0.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0, out_illegal=0. in_ready=1 one cycle after reset release.
- Accept: a request transfers when in_valid && in_ready. in_* may change freely when not accepted.
- Stage 1 (S1) registers op, word, a, tag, and the effective amount:
  - word=1: amt_eff = {1'b0, in_amt[4:0]}, in_amt[5] ignored.
  - word=0: amt_eff = in_amt.
- Stage 2 (S2) registers the result and drives out_*.
- Latency: exactly 2 cycles from acceptance to out_valid with no backpressure. Throughput 1 per cycle.
- Stall rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
  - S2 loads from S1 when s2_adv; S1 loads from input when s1_adv.
  - When not advancing, a stage holds its contents, and out_data/out_tag stay stable while out_valid && !out_ready.
- Word ops:
  - Source is a[31:0].
  - SRA uses a[31] as fill.
  - Rotates rotate within 32 bits.
  - Result is sign-extended from bit 31.
- Amount 0: result = a, or sext(a[31:0]) for word ops.
- Illegal op (101-111, or a rotate with the feature disabled): out_data=0, out_illegal=1, tag passes through; the pipeline is not affected.
- flush: next edge clears s1_valid and s2_valid; a request presented in the same cycle is dropped, and in_ready is forced 0 during flush. Flush overrides out_ready.
- Reset mid-operation discards all in-flight requests; there is no partial output.

Optional Feature:
- Macro: SHIFT_EXEC_ROTATE_EN.
- Defined: ROL/ROR implemented (64-bit, or 32-bit when word=1).
- Undefined: ops 011/100 are treated as illegal (out_data=0, out_illegal=1), and the rotate muxing is removed from the shift core.

Decomposition:
- Shared package shift_pkg:
  - op encoding constants SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_ROL, SHOP_ROR, and their 3-bit type.
  - XLEN default.
  - WORD_AMT_MASK.
- One sub-module, shift_core: combinational, 6 log stages (1/2/4/8/16/32), each gated by its own amount bit.
  - Inputs: a, amt, left, arith, rotate, word.
  - Output: result.
- All pipeline registers and the handshake live in shift_exec_pipe.

Test Plan:
- SLL, a=0x0000_0000_0000_0001, amt=63, word=0 -> out_data=0x8000_0000_0000_0000, out_valid exactly 2 cycles after acceptance.
- SRA, a=0x8000_0000_0000_0000, amt=4 -> 0xF800_0000_0000_0000. SRL with the same inputs -> 0x0800_0000_0000_0000.
- Word SLL, a=0x0000_0000_4000_0000, amt=0x21 (bit 5 ignored, effective 1) -> 0xFFFF_FFFF_8000_0000. Word SRA, a=0x0000_0000_8000_0000, amt=31 -> 0xFFFF_FFFF_FFFF_FFFF.
- Back-to-back 8 requests with tags 0..7 and out_ready held low for 5 cycles mid-stream:
  - in_ready drops within the same cycle once both stages are full.
  - Results emerge in order with no loss or duplication.
  - out_data is stable while stalled.
- flush asserted with both stages valid plus a new in_valid -> next cycle out_valid=0, no result for any of the three tags; rst_n pulsed mid-stream -> all outputs 0 asynchronously.
- With SHIFT_EXEC_ROTATE_EN: ROR a=0x1, amt=1 -> 0x8000_0000_0000_0000. Without it: same request -> out_data=0, out_illegal=1. Op 111 -> out_illegal=1 in both builds.
